// File: rtl/fsk_frame_receiver.sv
// =============================================================================
// Module      : fsk_frame_receiver
// Description : FSK bit slicer (rising edges counted per bit window) with a
//               sync-word hunt and Hamming codeword assembly.
//               Optional macro FSK_GLITCH_FILTER_EN adds a majority-of-3 filter.
// Revision    : 1.0 - initial release
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module fsk_frame_receiver #(
    parameter int         CLKS_PER_BIT = 16,
    parameter int         EDGE_THRESH  = 3,
    parameter int         CODE_W       = 14,
    parameter logic [7:0] SYNC_WORD    = 8'hB4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fsk_in,
    output logic              bit_strobe,
    output logic              bit_value,
    output logic              sync_lock,
    output logic [CODE_W-1:0] code_out,
    output logic              code_valid
);

    localparam int WIN_W  = $clog2(CLKS_PER_BIT);
    localparam int EDGE_W = WIN_W + 1;
    localparam int CNT_W  = $clog2(CODE_W + 1);

    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(CLKS_PER_BIT - 1);
    localparam logic [EDGE_W-1:0] EDGE_MAX = {EDGE_W{1'b1}};
    localparam logic [EDGE_W:0]   THRESH   = (EDGE_W + 1)'(EDGE_THRESH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CODE_W - 1);

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
    logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic                bit_strobe_q, bit_strobe_d;
    logic                bit_value_q, bit_value_d;
    logic [7:0]          sync_sr_q, sync_sr_d;
    logic [CODE_W-1:0]   data_sr_q, data_sr_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CODE_W-1:0]   code_out_q, code_out_d;
    logic                code_valid_q, code_valid_d;

    logic                det_w;
    logic                rise_w;
    logic                win_end_w;
    logic [EDGE_W:0]     edge_sum_w;

`ifdef FSK_GLITCH_FILTER_EN
    logic s2_h1_q, s2_h1_d, s2_h2_q, s2_h2_d, filt_q, filt_d;
    assign det_w = filt_q;
`else
    assign det_w = s2_q;
`endif

    assign rise_w     = det_w & ~s3_q;
    assign win_end_w  = (win_cnt_q == WIN_LAST);
    // A rise in the window-end cycle still belongs to the closing window.
    assign edge_sum_w = {1'b0, edge_cnt_q} + (EDGE_W + 1)'(rise_w);

    always_comb begin
        s1_d         = fsk_in;
        s2_d         = s1_q;
        s3_d         = det_w;
        win_cnt_d    = win_end_w ? '0 : win_cnt_q + 1'b1;
        edge_cnt_d   = edge_cnt_q;
        bit_strobe_d = win_end_w;
        bit_value_d  = bit_value_q;
        state_d      = state_q;
        sync_sr_d    = sync_sr_q;
        data_sr_d    = data_sr_q;
        bit_cnt_d    = bit_cnt_q;
        code_out_d   = code_out_q;
        code_valid_d = 1'b0;
`ifdef FSK_GLITCH_FILTER_EN
        s2_h1_d = s2_q;
        s2_h2_d = s2_h1_q;
        filt_d  = (s2_q & s2_h1_q) | (s2_q & s2_h2_q) | (s2_h1_q & s2_h2_q);
`endif

        if (win_end_w) begin
            edge_cnt_d  = '0;
            bit_value_d = (edge_sum_w >= THRESH);
        end else if (rise_w && (edge_cnt_q != EDGE_MAX)) begin
            edge_cnt_d = edge_cnt_q + 1'b1;
        end

        if (bit_strobe_q) begin
            case (state_q)
                HUNT: begin
                    sync_sr_d = {sync_sr_q[6:0], bit_value_q};
                    if (sync_sr_d == SYNC_WORD) begin
                        state_d   = RECV;
                        bit_cnt_d = '0;
                    end
                end
                RECV: begin
                    data_sr_d = {data_sr_q[CODE_W-2:0], bit_value_q};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CNT_LAST) begin
                        code_out_d   = data_sr_d;
                        code_valid_d = 1'b1;
                        state_d      = HUNT;
                        sync_sr_d    = '0;
                        bit_cnt_d    = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= HUNT;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            win_cnt_q    <= '0;
            edge_cnt_q   <= '0;
            bit_strobe_q <= 1'b0;
            bit_value_q  <= 1'b0;
            sync_sr_q    <= '0;
            data_sr_q    <= '0;
            bit_cnt_q    <= '0;
            code_out_q   <= '0;
            code_valid_q <= 1'b0;
`ifdef FSK_GLITCH_FILTER_EN
            s2_h1_q      <= 1'b0;
            s2_h2_q      <= 1'b0;
            filt_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            win_cnt_q    <= win_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_strobe_q <= bit_strobe_d;
            bit_value_q  <= bit_value_d;
            sync_sr_q    <= sync_sr_d;
            data_sr_q    <= data_sr_d;
            bit_cnt_q    <= bit_cnt_d;
            code_out_q   <= code_out_d;
            code_valid_q <= code_valid_d;
`ifdef FSK_GLITCH_FILTER_EN
            s2_h1_q      <= s2_h1_d;
            s2_h2_q      <= s2_h2_d;
            filt_q       <= filt_d;
`endif
        end
    end

    assign bit_strobe = bit_strobe_q;
    assign bit_value  = bit_value_q;
    assign sync_lock  = (state_q == RECV);
    assign code_out   = code_out_q;
    assign code_valid = code_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_fsk_frame_receiver.sv
// =============================================================================
// Module      : tb_fsk_frame_receiver
// Description : Scoreboard bench for fsk_frame_receiver (directed frames).
// Revision    : 1.0 - initial release
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fsk_frame_receiver;

    localparam logic [15:0] MARK    = 16'hCCCC;  // rises at 2,6,10,14
    localparam logic [15:0] SPACE   = 16'hFF00;  // rise at 8
    localparam logic [15:0] TWO_R   = 16'h0618;  // rises at 3,9
    localparam logic [15:0] THREE_E = 16'h8660;  // rises at 5,9,15 (window end)
    localparam logic [15:0] HOLD_HI = 16'h00FF;  // continues high, no rise
    localparam logic [15:0] GLITCH  = 16'hFF24;  // space plus spikes at 2,5
`ifdef FSK_GLITCH_FILTER_EN
    localparam int  IDLE_CYC   = 12;
    localparam logic GLITCH_BIT = 1'b0;
`else
    localparam int  IDLE_CYC   = 14;
    localparam logic GLITCH_BIT = 1'b1;
`endif

    typedef struct packed {
        logic b;
        logic lk;
    } bit_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        fsk_in;
    logic        bit_strobe;
    logic        bit_value;
    logic        sync_lock;
    logic [13:0] code_out;
    logic        code_valid;

    bit_exp_t    exp_bits[$];
    logic [13:0] exp_codes[$];
    int          checks = 0;
    int          errors = 0;
    int          valid_cnt = 0;
    logic        prev_valid = 1'b0;

    fsk_frame_receiver dut (
        .clk        (clk),
        .reset      (reset),
        .fsk_in     (fsk_in),
        .bit_strobe (bit_strobe),
        .bit_value  (bit_value),
        .sync_lock  (sync_lock),
        .code_out   (code_out),
        .code_valid (code_valid)
    );

    always #5 clk = ~clk;

    // Monitor: pops expectations whenever the DUT presents a bit or a codeword.
    always @(negedge clk) begin
        if (!reset) begin
            if (bit_strobe) begin
                checks++;
                if (exp_bits.size() == 0) begin
                    errors++;
                    $display("FAIL bit_strobe_unexpected: got bit=%0b lock=%0b, expected no strobe",
                             bit_value, sync_lock);
                end else begin
                    bit_exp_t e;
                    e = exp_bits.pop_front();
                    if ({bit_value, sync_lock} !== {e.b, e.lk}) begin
                        errors++;
                        $display("FAIL bit_decision: got bit=%0b lock=%0b, expected bit=%0b lock=%0b",
                                 bit_value, sync_lock, e.b, e.lk);
                    end
                end
            end
            if (code_valid) begin
                valid_cnt++;
                checks++;
                if (prev_valid) begin
                    errors++;
                    $display("FAIL code_valid_double: got two consecutive pulses, expected one");
                end
                checks++;
                if (exp_codes.size() == 0) begin
                    errors++;
                    $display("FAIL code_unexpected: got code=%h, expected no code_valid", code_out);
                end else begin
                    logic [13:0] ec;
                    ec = exp_codes.pop_front();
                    if ({code_out, sync_lock} !== {ec, 1'b0}) begin
                        errors++;
                        $display("FAIL code_out: got code=%h lock=%0b, expected code=%h lock=0",
                                 code_out, sync_lock, ec);
                    end
                end
            end
        end
        prev_valid = code_valid;
    end

    task automatic step(input logic v);
        fsk_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic send_wave(input logic [15:0] pat, input logic b, input logic lk);
        bit_exp_t e;
        e.b  = b;
        e.lk = lk;
        exp_bits.push_back(e);
        for (int c = 0; c < 16; c++) step(pat[c]);
    endtask

    task automatic send_bit(input logic b, input logic lk);
        send_wave(b ? MARK : SPACE, b, lk);
    endtask

    task automatic send_sync();
        logic [7:0] sw;
        sw = 8'hB4;
        for (int i = 7; i >= 0; i--) send_bit(sw[i], 1'b0);
    endtask

    task automatic send_payload(input logic [13:0] cw, input int nbits);
        for (int i = 13; i > 13 - nbits; i--) send_bit(cw[i], 1'b1);
    endtask

    task automatic send_frame(input logic [13:0] cw);
        send_sync();
        send_payload(cw, 14);
        exp_codes.push_back(cw);
    endtask

    task automatic do_reset();
        bit_exp_t e;
        reset  = 1'b1;
        fsk_in = 1'b0;
        exp_bits.delete();
        #1;
        checks++;
        if ({bit_strobe, bit_value, sync_lock, code_out, code_valid} !== 18'd0) begin
            errors++;
            $display("FAIL reset_outputs: got strobe=%0b bit=%0b lock=%0b code=%h valid=%0b, expected all 0",
                     bit_strobe, bit_value, sync_lock, code_out, code_valid);
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        // Window 0 after reset sees an idle line and decides 0.
        e.b  = 1'b0;
        e.lk = 1'b0;
        exp_bits.push_back(e);
        for (int i = 0; i < IDLE_CYC; i++) step(1'b0);
    endtask

    initial begin
        reset  = 1'b0;
        fsk_in = 1'b0;
        #2;
        do_reset();

        // Noise then single frame.
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_frame(14'h2A5C);

        // Back-to-back frames.
        send_frame(14'h0001);
        send_frame(14'h3FFE);

        // Payload containing the sync pattern, then idle spaces.
        send_frame(14'h0B4F);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);

        // Threshold boundaries and glitch rejection.
        send_wave(TWO_R,   1'b0, 1'b0);
        send_wave(THREE_E, 1'b1, 1'b0);
        send_wave(HOLD_HI, 1'b0, 1'b0);
        send_wave(GLITCH,  GLITCH_BIT, 1'b0);

        // Reset in the middle of a payload, then a clean frame.
        send_sync();
        send_payload(14'h1234, 6);
        do_reset();
        send_frame(14'h1B6D);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);

        for (int i = 0; i < 200 && exp_bits.size() != 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        checks++;
        if (exp_bits.size() != 0) begin
            errors++;
            $display("FAIL bits_drained: got %0d pending strobes, expected 0", exp_bits.size());
        end
        checks++;
        if (exp_codes.size() != 0) begin
            errors++;
            $display("FAIL codes_drained: got %0d pending codewords, expected 0", exp_codes.size());
        end
        checks++;
        if (valid_cnt != 5) begin
            errors++;
            $display("FAIL valid_count: got %0d code_valid pulses, expected 5", valid_cnt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
